uart_tx_frame_serializer: RTL and testbench

//  Parametrised UART TX frame engine: captures a DATA_WIDTH-bit word and emits a complete

---
 rtl/uart_tx_frame_serializer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_frame_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer: UART TX frame engine. Emits start, DATA_WIDTH data bits,
// optional parity and STOP_BITS stop bits on tx_out, one bit per clk (baud tick).
// Build option TX_SER_MSB_FIRST_EN: when defined, data bits go out MSB first;
// otherwise LSB first.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame_serializer: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_data_width
    $error("uart_tx_frame_serializer: DATA_WIDTH must be 2..32");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic                    r_par_en, w_par_en_nxt;
  logic                    r_par_typ, w_par_typ_nxt;
  logic                    r_tx, w_tx_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;

  logic                    w_ser_bit;
  logic [DATA_WIDTH-1:0]   w_shift_rot;
  logic                    w_par_bit;

  // The shift register rotates rather than shifts: after DATA_WIDTH rotations
  // it holds the captured word again, and rotation never changes its XOR, so
  // parity is always taken from the original captured word.
`ifdef TX_SER_MSB_FIRST_EN
  assign w_ser_bit   = r_shift[DATA_WIDTH-1];
  assign w_shift_rot = {r_shift[DATA_WIDTH-2:0], r_shift[DATA_WIDTH-1]};
`else
  assign w_ser_bit   = r_shift[0];
  assign w_shift_rot = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
`endif

  assign w_par_bit = (^r_shift) ^ r_par_typ;

  assign tx_out   = r_tx;
  assign busy     = r_busy;
  assign ser_done = r_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (data_valid) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_DATA;
      S_DATA:   if (r_cnt == LAST_BIT) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: w_state_nxt = S_STOP;
      S_STOP:   if (r_cnt == LAST_STOP) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered so each value
  // belongs to the state being entered on the coming edge
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_par_en_nxt  = r_par_en;
    w_par_typ_nxt = r_par_typ;
    w_tx_nxt      = 1'b1;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_shift_nxt   = p_data;
          w_par_en_nxt  = par_en;
          w_par_typ_nxt = par_typ;
          w_tx_nxt      = 1'b0;
        end
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_tx_nxt    = w_ser_bit;
        w_shift_nxt = w_shift_rot;
      end
      S_DATA: begin
        if (r_cnt == LAST_BIT) begin
          w_cnt_nxt = '0;
          w_tx_nxt  = r_par_en ? w_par_bit : 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_tx_nxt    = w_ser_bit;
          w_shift_nxt = w_shift_rot;
        end
      end
      S_PARITY: begin
        w_cnt_nxt = '0;
      end
      S_STOP: begin
        if (r_cnt == LAST_STOP) w_cnt_nxt = '0;
        else                    w_cnt_nxt = r_cnt + CW'(1);
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_typ <= w_par_typ_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb_uart_tx_frame_serializer: directed vectors for uart_tx_frame_serializer.
// Two instances share inputs: dut1 with one stop bit, dut2 with two.
// Honours TX_SER_MSB_FIRST_EN for the expected data-bit order.
module tb_uart_tx_frame_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] seq;

  always #5 clk = ~clk;

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx1), .busy(busy1), .ser_done(done1)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx2), .busy(busy2), .ser_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a frame; after return the start bit is on the line
  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Record n line bits (first bit ends up at seq[n-1]) and check busy on each;
  // inj: bit slot in which a 8'h3C request is pulsed (-1 = none);
  // hold: keep data_valid high the whole time. Returns in the ser_done cycle.
  task automatic capture(input int sel, input int n, input int inj, input logic hold,
                         output logic [15:0] s);
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = {s[14:0], (sel == 2) ? tx2 : tx1};
      chk("busy_in_frame", {31'd0, (sel == 2) ? busy2 : busy1}, 32'd1);
      chk("done_in_frame", {31'd0, (sel == 2) ? done2 : done1}, 32'd0);
      if (i == inj) begin
        p_data     = 8'h3C;
        par_en     = ~par_en;
        data_valid = 1'b1;
      end else begin
        data_valid = hold;
      end
      tick();
    end
    chk("done_pulse", {31'd0, (sel == 2) ? done2 : done1}, 32'd1);
    chk("busy_fall",  {31'd0, (sel == 2) ? busy2 : busy1}, 32'd0);
    chk("tx_idle_at_done", {31'd0, (sel == 2) ? tx2 : tx1}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 rst = 1'b0;
    #1;
    chk("rst_tx",   {31'd0, tx1},   32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_tx",   {31'd0, tx1},   32'd1);
    chk("idle_busy", {31'd0, busy1}, 32'd0);

    // 1: A5, no parity, 1 stop -> 0,10100101,1 (palindrome: same both orders)
    start(8'hA5, 1'b0, 1'b0);
    capture(1, 10, -1, 1'b0, seq);
    chk("t1_frame", {22'd0, seq[9:0]}, {22'd0, 10'b0101001011});
    tick();
    chk("t1_done_clear", {31'd0, done1}, 32'd0);
    chk("t1_line_idle",  {31'd0, tx1},   32'd1);
    repeat (3) tick();

    // 2: 07 even parity = 1, then odd parity = 0; 11-cycle frames
    start(8'h07, 1'b1, 1'b0);
    capture(1, 11, -1, 1'b0, seq);
`ifdef TX_SER_MSB_FIRST_EN
    chk("t2_even_frame", {21'd0, seq[10:0]}, {21'd0, 11'b00000011111});
`else
    chk("t2_even_frame", {21'd0, seq[10:0]}, {21'd0, 11'b01110000011});
`endif
    repeat (4) tick();
    start(8'h07, 1'b1, 1'b1);
    capture(1, 11, -1, 1'b0, seq);
`ifdef TX_SER_MSB_FIRST_EN
    chk("t2_odd_frame", {21'd0, seq[10:0]}, {21'd0, 11'b00000011101});
`else
    chk("t2_odd_frame", {21'd0, seq[10:0]}, {21'd0, 11'b01110000001});
`endif
    repeat (4) tick();

    // 3: two stop bits, odd parity, A5 -> parity 1, 12-cycle frame
    start(8'hA5, 1'b1, 1'b1);
    capture(2, 12, -1, 1'b0, seq);
    chk("t3_frame", {20'd0, seq[11:0]}, {20'd0, 12'b010100101111});
    tick();
    chk("t3_done_clear", {31'd0, done2}, 32'd0);
    repeat (3) tick();

    // 4a: request during DATA is ignored, frame A5 unchanged, no second frame
    start(8'hA5, 1'b0, 1'b0);
    capture(1, 10, 3, 1'b0, seq);
    chk("t4_frame_unchanged", {22'd0, seq[9:0]}, {22'd0, 10'b0101001011});
    tick();
    chk("t4_no_second_busy", {31'd0, busy1}, 32'd0);
    chk("t4_no_second_tx",   {31'd0, tx1},   32'd1);
    tick();
    chk("t4_still_idle", {31'd0, busy1}, 32'd0);
    repeat (3) tick();

    // 4b: request held through ser_done -> 3C frame starts on the next edge
    start(8'hA5, 1'b0, 1'b0);
    p_data = 8'h3C;
    par_en = 1'b0;
    capture(1, 10, -1, 1'b1, seq);
    chk("t4b_first_frame", {22'd0, seq[9:0]}, {22'd0, 10'b0101001011});
    tick();
    data_valid = 1'b0;
    chk("t4b_next_busy", {31'd0, busy1}, 32'd1);
    chk("t4b_next_start", {31'd0, tx1},  32'd0);
    chk("t4b_next_done", {31'd0, done1}, 32'd0);
    capture(1, 10, -1, 1'b0, seq);
    chk("t4b_3c_frame", {22'd0, seq[9:0]}, {22'd0, 10'b0001111001});
    repeat (4) tick();

    // 5: asynchronous reset during DATA bit 4
    start(8'hA5, 1'b0, 1'b0);
    repeat (5) tick();
    chk("t5_pre_busy", {31'd0, busy1}, 32'd1);
    chk("t5_pre_bit4", {31'd0, tx1},   32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_tx",   {31'd0, tx1},   32'd1);
    chk("t5_rst_busy", {31'd0, busy1}, 32'd0);
    chk("t5_rst_done", {31'd0, done1}, 32'd0);
    chk("t5_rst_busy2", {31'd0, busy2}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("t5_idle_tx",   {31'd0, tx1},   32'd1);
      chk("t5_idle_busy", {31'd0, busy1}, 32'd0);
      chk("t5_idle_done", {31'd0, done1}, 32'd0);
    end

    // 6: bit order with 0F
    start(8'h0F, 1'b0, 1'b0);
    capture(1, 10, -1, 1'b0, seq);
`ifdef TX_SER_MSB_FIRST_EN
    chk("t6_frame", {22'd0, seq[9:0]}, {22'd0, 10'b0000011111});
`else
    chk("t6_frame", {22'd0, seq[9:0]}, {22'd0, 10'b0111100001});
`endif
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
